adder_sched: RTL and testbench
==============================

ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 SHALL have parameter NBYTES, default 4: operand width in bytes; legal range 2..8.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each: requester 0/1 has an operation pending.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each: requester 0/1 is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 8*NBYTES each: operands.
REQ-007 SHALL have ports req0_cin and req1_cin, input, 1 each: carry-in.
REQ-008 SHALL have port res_valid, output, 1: result available.
REQ-009 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port res_id, output, 1: index of the requester that owns the result.
REQ-011 SHALL have port res_sum, output, 8*NBYTES: the sum.
REQ-012 SHALL have port res_cout, output, 1: carry out of the MSB.
REQ-013 SHALL have port res_ovf, output, 1: two's-complement signed overflow.
REQ-014 SHALL have port busy, output, 1: high in BUSY or DONE.

Function
REQ-015 SHALL contain exactly one 8-bit adder with carry: 9-bit result = a_byte + b_byte + carry. It is time-shared across bytes and across requesters.
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
- IDLE -> BUSY on a request handshake.
- BUSY -> DONE after NBYTES cycles.
- DONE -> IDLE on res_valid && res_ready.
REQ-017 In IDLE, reqN_ready SHALL be asserted only for the granted requester. Grant rules:
- only one valid: that requester.
- both valid: the requester not served last (round-robin).
- neither valid: no grant.
REQ-018 reqN_ready SHALL be 0 in BUSY and DONE. reqN_ready may depend combinationally on req0_valid/req1_valid.
REQ-019 A handshake (reqN_valid && reqN_ready) SHALL latch a, b, cin and the requester index. It SHALL also reset the byte counter to 0 and update the last-served pointer.
REQ-020 In BUSY cycle k (k = 0..NBYTES-1), byte k SHALL be computed.
- Carry-in for k=0 is the latched cin; for k>0 it is the registered carry from byte k-1.
- Sum byte k SHALL be written into res_sum[8k+7:8k] at the end of cycle k.
REQ-021 Latency: res_valid SHALL rise exactly NBYTES+1 rising edges after the accepting edge.
REQ-022 res_sum, res_cout, res_ovf and res_id SHALL hold stable while res_valid=1.
REQ-023 res_cout SHALL equal the carry out of byte NBYTES-1.
REQ-024 res_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-025 res_valid SHALL stay high until res_ready=1. The FSM SHALL wait in DONE indefinitely, with no timeout.
REQ-026 The earliest next acceptance SHALL be the cycle after the result handshake (no overlap).
REQ-027 Request valid inputs that deassert before being granted SHALL be ignored; no request is lost if held.
REQ-028 Operand inputs SHALL be ignored outside the accept cycle.
REQ-029 Wrap-around: all-ones + 1 with cin=0 SHALL give res_sum=0 and res_cout=1.

Reset
REQ-030 rst_n=0 SHALL immediately force all of the following, asynchronously:
- state=IDLE, byte counter=0.
- res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, busy=0.
- last-served pointer=1, so requester 0 wins the first contention.
REQ-031 Reset asserted mid-operation (BUSY or DONE) SHALL abort the operation and discard any partial result; no result is ever presented for it.
REQ-032 After rst_n deasserts, the first handshake SHALL be possible on the first rising edge.

Verification
REQ-033 Single request (NBYTES=4):
- stimulus: req0 a=0x0000_00FF, b=0x0000_0001, cin=0.
- response: res_sum=0x0000_0100, cout=0, ovf=0, id=0; res_valid on the 5th edge after accept.
REQ-034 Carry chain and wrap:
- stimulus: a=0xFFFF_FFFF, b=0x0000_0000, cin=1.
- response: res_sum=0, cout=1, ovf=0.
REQ-035 Signed overflow:
- stimulus: a=0x7FFF_FFFF, b=0x0000_0001, cin=0.
- response: res_sum=0x8000_0000, cout=0, ovf=1.
REQ-036 Contention:
- stimulus: both requesters hold valid continuously after reset.
- response: grants go 0,1,0,1; res_id matches each grant; no request is dropped.
REQ-037 Backpressure:
- stimulus: res_ready=0 for 10 cycles in DONE.
- response: res_valid and all result fields stay constant; req ready stays 0; the result completes when res_ready=1.
REQ-038 Reset mid-op:
- stimulus: rst_n pulsed low during BUSY byte 2.
- response: outputs go 0 immediately; no res_valid for the aborted operation; the next request from req0 completes normally.

Source files
------------

// File: rtl/adder_sched.sv
// Two-requester add scheduler: one 8-bit adder is time-shared byte-serially,
// LSB first, across both requesters. Round-robin grant, one operation in flight.
module adder_sched #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req0_cin,
    input  logic                  req1_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [8*NBYTES-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_ovf,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Handshake: a request is taken on a rising edge where reqN_valid && reqN_ready;
    // a result is consumed on a rising edge where res_valid && res_ready.
    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NBYTES-1:0][7:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                     carry_q, carry_d;
    logic                     id_q, id_d;
    logic                     last_q, last_d;
    logic                     cout_q, cout_d;
    logic                     ovf_q, ovf_d;

    logic                     grant0, grant1;
    logic [BW-1:0]            bidx;
    logic [8:0]               add;

    // last_q names the requester served most recently; the other wins a tie.
    assign grant0 = req0_valid && (!req1_valid || last_q);
    assign grant1 = req1_valid && (!req0_valid || !last_q);
    assign bidx   = cnt_q[BW-1:0];
    assign add    = {1'b0, a_q[bidx]} + {1'b0, b_q[bidx]} + {8'd0, carry_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        id_d       = id_q;
        last_d     = last_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    carry_d = grant1 ? req1_cin : req0_cin;
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Counts 0..NBYTES-1 compute bytes; the extra count presents the result.
                if (cnt_q == CW'(NBYTES)) begin
                    state_d = DONE;
                end else begin
                    sum_d[bidx] = add[7:0];
                    carry_d     = add[8];
                    cnt_d       = cnt_q + CW'(1);
                    if (cnt_q == CW'(NBYTES - 1)) begin
                        cout_d = add[8];
                        ovf_d  = a_q[bidx][7] ^ b_q[bidx][7] ^ add[7] ^ add[8];
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;
    assign res_id    = id_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched (NBYTES=4): reference-model scoreboard, directed
// arithmetic cases, round-robin contention, backpressure and mid-operation reset.
module tb_adder_sched;
    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam int EW = W + 3;
    localparam int LAT = NB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_cin, req1_cin;
    logic          res_valid, res_ready, res_id, res_cout, res_ovf, busy;
    logic [W-1:0]  res_sum;
    logic [1:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;

    adder_sched #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic id, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {id, full[W], ovf, full[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output logic ok);
        ok = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
        #1;
        for (int k = 0; k < 40; k++) begin
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                exp_q.push_back(model(id, a, b, cin));
                @(posedge clk);
                #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #2;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic ok);
        ok  = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1) begin
                lat = k;
                ok  = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_cin = 1'b0; req1_cin = 1'b0;
        #3;
        checks++;
        if ({res_valid, busy, res_sum, res_cout, res_ovf, res_id, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b sum=%h cout=%b ovf=%b id=%b st=%0d want all 0",
                     res_valid, busy, res_sum, res_cout, res_ovf, res_id, dbg_state);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, dbg_state} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got r0=%b r1=%b st=%0d want 0 0 0", req0_ready, req1_ready, dbg_state);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] tb [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] ts [4] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        logic         tco[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         tid[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic         ok;
        int           lat;
        logic [EW-1:0] exp;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(tid[i], ta[i], tb[i], tc[i], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL directed%0d_accept: got no grant want grant", i); continue; end
            wait_result(lat, ok);
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, LAT); end
            if (!ok) begin exp_q.delete(); continue; end
            exp = exp_q.pop_front();
            checks++;
            if ({res_sum, res_cout, res_ovf, res_id} !== {ts[i], tco[i], tov[i], tid[i]}) begin
                errors++;
                $display("FAIL directed%0d_result: got sum=%h cout=%b ovf=%b id=%b want sum=%h cout=%b ovf=%b id=%b",
                         i, res_sum, res_cout, res_ovf, res_id, ts[i], tco[i], tov[i], tid[i]);
            end
            checks++;
            if ({res_id, res_cout, res_ovf, res_sum} !== exp) begin
                errors++;
                $display("FAIL directed%0d_model: got %h want %h", i, {res_id, res_cout, res_ovf, res_sum}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic          ok;
        logic          id;
        int            lat, hold;
        logic [EW-1:0] exp, got;
        for (int i = 0; i < 8; i++) begin
            id        = 1'($urandom_range(0, 1));
            hold      = $urandom_range(0, 3);
            res_ready = (hold == 0);
            send(id, $urandom, $urandom, 1'($urandom_range(0, 1)), ok);
            wait_result(lat, ok);
            checks++;
            if (!ok || lat != LAT) begin
                errors++;
                $display("FAIL random%0d_latency: got %0d want %0d", i, lat, LAT);
                exp_q.delete();
                res_ready = 1'b1;
                @(posedge clk);
                #1;
                continue;
            end
            exp = exp_q.pop_front();
            got = {res_id, res_cout, res_ovf, res_sum};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random%0d_result: got %h want %h", i, got, exp); end
            repeat (hold) @(posedge clk);
            #1;
            checks++;
            if ({res_valid, res_id, res_cout, res_ovf, res_sum} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL random%0d_hold: got valid=%b %h want valid=1 %h", i, res_valid,
                         {res_id, res_cout, res_ovf, res_sum}, exp);
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL random%0d_release: got valid=%b want 0", i, res_valid); end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_contention();
        int            ng = 0;
        int            nr = 0;
        logic          gid;
        logic [EW-1:0] exp, got;
        do_reset();
        res_ready  = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
        req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 200 && nr < 4; cyc++) begin
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                gid = req1_ready;
                checks++;
                if ({req0_ready, req1_ready} === 2'b11 || gid !== 1'(ng % 2)) begin
                    errors++;
                    $display("FAIL contention_grant%0d: got r0=%b r1=%b want id %0d", ng, req0_ready, req1_ready, ng % 2);
                end
                exp_q.push_back(gid ? model(1'b1, req1_a, req1_b, req1_cin) : model(1'b0, req0_a, req0_b, req0_cin));
                ng++;
            end
            if (res_valid === 1'b1) begin
                got = {res_id, res_cout, res_ovf, res_sum};
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== exp) begin errors++; $display("FAIL contention_result%0d: got %h want %h", nr, got, exp); end
                nr++;
            end
            @(posedge clk);
            #1;
            if (ng >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            if (req0_valid && dbg_state == 2'd1) begin req0_a = $urandom; req0_b = $urandom; end
            if (req1_valid && dbg_state == 2'd1) begin req1_a = $urandom; req1_b = $urandom; end
            #1;
        end
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++;
            $display("FAIL contention_count: got grants=%0d results=%0d want 4 4", ng, nr);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic          ok;
        int            lat;
        logic [EW-1:0] exp, snap;
        res_ready = 1'b0;
        send(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1, ok);
        wait_result(lat, ok);
        checks++;
        if (!ok || lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        exp  = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        snap = {res_id, res_cout, res_ovf, res_sum};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", snap, exp); end
        req0_a = 32'hAAAA_0001; req0_b = 32'h5555_FFFF; req0_cin = 1'b1; req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({res_valid, res_id, res_cout, res_ovf, res_sum, req0_ready, req1_ready} !== {1'b1, exp, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b %h r0=%b r1=%b want valid=1 %h r0=0 r1=0", i, res_valid,
                         {res_id, res_cout, res_ovf, res_sum}, req0_ready, req1_ready, exp);
            end
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_no_overlap: got r0=%b want 0", req0_ready); end
        @(posedge clk);
        #1;
        checks++;
        if ({res_valid, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_next_accept: got valid=%b r0=%b want valid=0 r0=1", res_valid, req0_ready);
        end
        exp_q.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_result(lat, ok);
        checks++;
        if (!ok || lat != LAT) begin errors++; $display("FAIL bp_followup_latency: got %0d want %0d", lat, LAT); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({res_id, res_cout, res_ovf, res_sum} !== exp) begin
            errors++;
            $display("FAIL bp_followup_result: got %h want %h", {res_id, res_cout, res_ovf, res_sum}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic          ok;
        int            lat;
        logic [EW-1:0] exp;
        res_ready = 1'b1;
        send(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, ok);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL midrst_busy: got st=%0d want 1", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, busy, res_sum, res_cout, res_ovf, res_id, dbg_state} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got valid=%b busy=%b sum=%h cout=%b ovf=%b id=%b st=%0d want all 0",
                     res_valid, busy, res_sum, res_cout, res_ovf, res_id, dbg_state);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold%0d: got valid=%b want 0", i, res_valid); end
        end
        req0_a = 32'h0101_0101; req0_b = 32'h00FF_00FF; req0_cin = 1'b1; req0_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_first_edge: got r0=%b want 1", req0_ready); end
        exp_q.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_result(lat, ok);
        checks++;
        if (!ok || lat != LAT) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({res_id, res_cout, res_ovf, res_sum} !== exp) begin
            errors++;
            $display("FAIL midrst_result: got %h want %h", {res_id, res_cout, res_ovf, res_sum}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
